gt_drp_rmw: RTL and testbench



---
 rtl/gt_drp_rmw.sv | 200 ++++++++++++++++++++
 tb/tb_gt_drp_rmw.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gt_drp_rmw.sv
// gt_drp_rmw: read-modify-write sequencer in front of the GT DRP bridge.
// Takes one {addr, mask, data} command, reads, merges, writes back.
module gt_drp_rmw #(
  parameter int BUSY_LAT = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_addr,
  input  logic [15:0] cmd_mask,
  input  logic [15:0] cmd_data,
  output logic        drp_write,
  output logic [63:0] drp_din,
  input  logic [16:0] drp_dout,
  output logic        rsp_done,
  output logic [15:0] rsp_data,
  output logic        rsp_err
);

  typedef enum logic [3:0] {
    IDLE,
    RD_ISS,
    RD_SET,
    RD_WAIT,
    MOD,
    WR_ISS,
    WR_SET,
    WR_WAIT,
    DONE
  } state_t;

  localparam logic [10:0] TO_CNT  = 11'(TIMEOUT);
  localparam logic [10:0] LAT_CNT = 11'(BUSY_LAT);

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [8:0]  addr_q, addr_d;
  logic [15:0] mask_q, mask_d;
  logic [15:0] data_q, data_d;
  logic [15:0] old_q, old_d;
  logic        rd_only_q, rd_only_d;
  logic [63:0] din_q, din_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        busy;
  logic [15:0] merged;

  // Bridge din layout: data in [15:0], addr in [24:16], we in [31].
  function automatic logic [63:0] mk_din(
    input logic        we,
    input logic [8:0]  addr,
    input logic [15:0] data
  );
    return {32'h0, we, 6'h0, addr, data};
  endfunction

  assign busy   = drp_dout[16];
  assign merged = (old_q & ~mask_q) | (data_q & mask_q);

  // Strobes decode straight from state so reset drops them at once.
  assign cmd_ready = (state_q == IDLE) && !reset;
  assign drp_write = (state_q == RD_ISS) || (state_q == WR_ISS);
  assign rsp_done  = (state_q == DONE);
  assign drp_din   = din_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  // Next-state, datapath and response capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    data_d     = data_q;
    old_d      = old_q;
    rd_only_d  = rd_only_q;
    din_d      = din_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d    = cmd_addr;
          mask_d    = cmd_mask;
          data_d    = cmd_data;
          old_d     = '0;
          rd_only_d = (cmd_mask == 16'h0000);
          if (cmd_mask == 16'hFFFF) begin
            state_d = WR_ISS;
            din_d   = mk_din(1'b1, cmd_addr, cmd_data);
          end else begin
            state_d = RD_ISS;
            din_d   = mk_din(1'b0, cmd_addr, 16'h0);
          end
        end
      end
      RD_ISS: begin
        cnt_d   = '0;
        state_d = RD_SET;
      end
      RD_SET: begin
        cnt_d = cnt_q + 11'd1;
        if (cnt_d == TO_CNT) begin
          state_d    = DONE;
          rsp_err_d  = 1'b1;
          rsp_data_d = old_q;
        end else if (cnt_d >= LAT_CNT) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (!busy) begin
          old_d = drp_dout[15:0];
          if (rd_only_q) begin
            state_d    = DONE;
            rsp_err_d  = 1'b0;
            rsp_data_d = drp_dout[15:0];
          end else begin
            state_d = MOD;
          end
        end else begin
          cnt_d = cnt_q + 11'd1;
          if (cnt_d == TO_CNT) begin
            state_d    = DONE;
            rsp_err_d  = 1'b1;
            rsp_data_d = old_q;
          end
        end
      end
      MOD: begin
        state_d = WR_ISS;
        din_d   = mk_din(1'b1, addr_q, merged);
      end
      WR_ISS: begin
        cnt_d   = '0;
        state_d = WR_SET;
      end
      WR_SET: begin
        cnt_d = cnt_q + 11'd1;
        if (cnt_d == TO_CNT) begin
          state_d    = DONE;
          rsp_err_d  = 1'b1;
          rsp_data_d = old_q;
        end else if (cnt_d >= LAT_CNT) begin
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (!busy) begin
          state_d    = DONE;
          rsp_err_d  = 1'b0;
          rsp_data_d = old_q;
        end else begin
          cnt_d = cnt_q + 11'd1;
          if (cnt_d == TO_CNT) begin
            state_d    = DONE;
            rsp_err_d  = 1'b1;
            rsp_data_d = old_q;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      old_q      <= '0;
      rd_only_q  <= 1'b0;
      din_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
      old_q      <= old_d;
      rd_only_q  <= rd_only_d;
      din_q      <= din_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_gt_drp_rmw.sv
// tb_gt_drp_rmw: directed bench for gt_drp_rmw with a small bridge model.
// TIMEOUT is shortened to 16 so the stuck-busy case stays brief.
module tb_gt_drp_rmw;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_addr;
  logic [15:0] cmd_mask;
  logic [15:0] cmd_data;
  logic        drp_write;
  logic [63:0] drp_din;
  logic [16:0] drp_dout;
  logic        rsp_done;
  logic [15:0] rsp_data;
  logic        rsp_err;

  int n_chk;
  int n_fail;

  logic [15:0] rd_val;
  int          nbusy;
  logic        stuck;
  int          rem;

  logic [63:0] din_log[$];
  int          n_rd;
  int          n_wr;
  int          n_done;
  int          n_acc;
  logic [15:0] got_data;
  logic        got_err;

  gt_drp_rmw #(
    .BUSY_LAT(2),
    .TIMEOUT (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_mask (cmd_mask),
    .cmd_data (cmd_data),
    .drp_write(drp_write),
    .drp_din  (drp_din),
    .drp_dout (drp_dout),
    .rsp_done (rsp_done),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bridge model: busy for nbusy cycles after each write strobe.
  always @(posedge clock) begin
    if (drp_write) rem <= nbusy;
    else if (rem > 0) rem <= rem - 1;
  end
  assign drp_dout = {stuck || (rem != 0), rd_val};

  // Observe strobes, responses and accepts mid-cycle.
  always @(negedge clock) begin
    if (drp_write) begin
      din_log.push_back(drp_din);
      if (drp_din[31]) n_wr++;
      else n_rd++;
    end
    if (rsp_done) begin
      n_done++;
      got_data = rsp_data;
      got_err  = rsp_err;
    end
    if (cmd_valid && cmd_ready) n_acc++;
  end

  task automatic send(input logic [8:0] a, input logic [15:0] m,
                      input logic [15:0] d);
    int k;
    @(posedge clock); #1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_mask  = m;
    cmd_data  = d;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(posedge clock); #1;
      k++;
    end
    n_chk++;
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL send_ready: cmd_ready=%0b required 1", cmd_ready);
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, output int cyc);
    cyc = 0;
    while (n_done <= d0 && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
    end
    n_chk++;
    if (n_done <= d0) begin
      n_fail++;
      $display("FAIL done_wait: no rsp_done after %0d cycles", cyc);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_chk++;
    if (cmd_ready !== 1'b0 || drp_write !== 1'b0 || rsp_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: ready=%b write=%b done=%b required 0 0 0",
               cmd_ready, drp_write, rsp_done);
    end
    n_chk++;
    if (drp_din !== 64'h0 || rsp_data !== 16'h0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: din=%h data=%h err=%b required 0 0 0",
               drp_din, rsp_data, rsp_err);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    n_chk++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_rmw;
    int r0, w0, d0, l0, cyc;
    rd_val = 16'h1234;
    nbusy  = 2;
    r0 = n_rd; w0 = n_wr; d0 = n_done; l0 = din_log.size();
    send(9'h05A, 16'h00F0, 16'h00A0);
    wait_done(d0, cyc);
    n_chk++;
    if (n_rd - r0 != 1 || n_wr - w0 != 1) begin
      n_fail++;
      $display("FAIL rmw_strobes: rd=%0d wr=%0d required 1 1", n_rd - r0, n_wr - w0);
    end
    n_chk++;
    if (din_log.size() < l0 + 2 || din_log[l0] !== 64'h0000_0000_005A_0000) begin
      n_fail++;
      $display("FAIL rmw_rd_din: din=%h required 00000000005a0000",
               (din_log.size() > l0) ? din_log[l0] : 64'hx);
    end
    n_chk++;
    if (din_log.size() < l0 + 2 || din_log[l0+1] !== 64'h0000_0000_805A_12A4) begin
      n_fail++;
      $display("FAIL rmw_wr_din: din=%h required 00000000805a12a4",
               (din_log.size() > l0 + 1) ? din_log[l0+1] : 64'hx);
    end
    n_chk++;
    if (got_data !== 16'h1234 || got_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_rsp: data=%h err=%b required 1234 0", got_data, got_err);
    end
  endtask

  task automatic test_write_only;
    int r0, w0, d0, l0, cyc;
    nbusy = 1;
    r0 = n_rd; w0 = n_wr; d0 = n_done; l0 = din_log.size();
    send(9'h1FF, 16'hFFFF, 16'hBEEF);
    wait_done(d0, cyc);
    n_chk++;
    if (n_rd != r0 || n_wr - w0 != 1) begin
      n_fail++;
      $display("FAIL wo_strobes: rd=%0d wr=%0d required 0 1", n_rd - r0, n_wr - w0);
    end
    n_chk++;
    if (din_log.size() != l0 + 1 || din_log[l0] !== 64'h0000_0000_81FF_BEEF) begin
      n_fail++;
      $display("FAIL wo_din: n=%0d din=%h required 1 0000000081ffbeef",
               din_log.size() - l0, (din_log.size() > l0) ? din_log[l0] : 64'hx);
    end
    n_chk++;
    if (got_data !== 16'h0000 || got_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wo_rsp: data=%h err=%b required 0000 0", got_data, got_err);
    end
  endtask

  task automatic test_read_only;
    int r0, w0, d0, l0, cyc;
    rd_val = 16'hCAFE;
    nbusy  = 3;
    r0 = n_rd; w0 = n_wr; d0 = n_done; l0 = din_log.size();
    send(9'h023, 16'h0000, 16'h5555);
    wait_done(d0, cyc);
    repeat (4) @(posedge clock);
    #1;
    n_chk++;
    if (n_rd - r0 != 1 || n_wr != w0 || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL ro_counts: rd=%0d wr=%0d done=%0d required 1 0 1",
               n_rd - r0, n_wr - w0, n_done - d0);
    end
    n_chk++;
    if (din_log.size() < l0 + 1 || din_log[l0] !== 64'h0000_0000_0023_0000) begin
      n_fail++;
      $display("FAIL ro_din: din=%h required 0000000000230000",
               (din_log.size() > l0) ? din_log[l0] : 64'hx);
    end
    n_chk++;
    if (got_data !== 16'hCAFE || got_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ro_rsp: data=%h err=%b required cafe 0", got_data, got_err);
    end
  endtask

  task automatic test_timeout;
    int w0, d0, l0, cyc;
    stuck  = 1'b1;
    rd_val = 16'h1234;
    nbusy  = 0;
    w0 = n_wr; d0 = n_done;
    send(9'h077, 16'h00FF, 16'h0011);
    wait_done(d0, cyc);
    n_chk++;
    if (cyc > 20) begin
      n_fail++;
      $display("FAIL to_latency: %0d cycles required <= 20", cyc);
    end
    n_chk++;
    if (got_err !== 1'b1 || n_wr != w0) begin
      n_fail++;
      $display("FAIL to_err: err=%b wr=%0d required 1 0", got_err, n_wr - w0);
    end
    stuck = 1'b0;
    nbusy = 1;
    d0 = n_done; l0 = din_log.size();
    send(9'h010, 16'hFF00, 16'hAB00);
    wait_done(d0, cyc);
    n_chk++;
    if (got_err !== 1'b0 || got_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL to_recover: err=%b data=%h required 0 1234", got_err, got_data);
    end
    n_chk++;
    if (din_log.size() < l0 + 2 || din_log[l0+1] !== 64'h0000_0000_8010_AB34) begin
      n_fail++;
      $display("FAIL to_recover_din: din=%h required 000000008010ab34",
               (din_log.size() > l0 + 1) ? din_log[l0+1] : 64'hx);
    end
  endtask

  task automatic test_backpressure;
    int a0, d0, n_rdy, k;
    logic seen;
    rd_val = 16'h0F0F;
    nbusy  = 3;
    a0 = n_acc; d0 = n_done;
    @(posedge clock); #1;
    cmd_valid = 1'b1;
    cmd_addr  = 9'h100;
    cmd_mask  = 16'h00FF;
    cmd_data  = 16'h0033;
    @(posedge clock); #1;
    n_rdy = 0;
    seen  = 1'b0;
    k     = 0;
    while (!seen && k < 60) begin
      @(negedge clock);
      if (rsp_done) seen = 1'b1;
      else if (cmd_ready) n_rdy++;
      k++;
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(negedge clock);
    n_chk++;
    if (!seen || n_rdy != 0) begin
      n_fail++;
      $display("FAIL bp_busy_ready: done=%b ready_cycles=%0d required 1 0", seen, n_rdy);
    end
    n_chk++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_after: cmd_ready=%b required 1", cmd_ready);
    end
    n_chk++;
    if (n_acc - a0 != 1 || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL bp_accepts: acc=%0d done=%0d required 1 1", n_acc - a0, n_done - d0);
    end
    n_chk++;
    if (got_data !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL bp_rsp: data=%h required 0f0f", got_data);
    end
  endtask

  task automatic test_reset_mid_op;
    int r0, d0, l0, k, cyc;
    rd_val = 16'h7777;
    nbusy  = 10;
    r0 = n_rd;
    send(9'h044, 16'h00F0, 16'h0010);
    k = 0;
    while (n_rd == r0 && k < 20) begin
      @(posedge clock); #1;
      k++;
    end
    repeat (2) @(posedge clock);
    #1;
    n_chk++;
    if (n_rd == r0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_busy: rd_seen=%0d ready=%b required 1 0", n_rd - r0, cmd_ready);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if (cmd_ready !== 1'b0 || drp_write !== 1'b0 || rsp_done !== 1'b0 ||
        drp_din !== 64'h0 || rsp_data !== 16'h0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: rdy=%b wr=%b done=%b din=%h data=%h err=%b required all 0",
               cmd_ready, drp_write, rsp_done, drp_din, rsp_data, rsp_err);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    n_chk++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_release: cmd_ready=%b required 1", cmd_ready);
    end
    rd_val = 16'hFFFF;
    nbusy  = 2;
    d0 = n_done; l0 = din_log.size();
    send(9'h0C3, 16'h0F0F, 16'h5A5A);
    wait_done(d0, cyc);
    n_chk++;
    if (got_data !== 16'hFFFF || got_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_fresh_rsp: data=%h err=%b required ffff 0", got_data, got_err);
    end
    n_chk++;
    if (din_log.size() < l0 + 2 || din_log[l0+1] !== 64'h0000_0000_80C3_FAFA) begin
      n_fail++;
      $display("FAIL mid_fresh_din: din=%h required 0000000080c3fafa",
               (din_log.size() > l0 + 1) ? din_log[l0+1] : 64'hx);
    end
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    n_rd      = 0;
    n_wr      = 0;
    n_done    = 0;
    n_acc     = 0;
    got_data  = '0;
    got_err   = 1'b0;
    rem       = 0;
    rd_val    = '0;
    nbusy     = 0;
    stuck     = 1'b0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_mask  = '0;
    cmd_data  = '0;
    test_reset();
    test_rmw();
    test_write_only();
    test_read_only();
    test_timeout();
    test_backpressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
